// File: rtl/firebird7_in_gate1_tessent_data_mux_sw.sv
// Multi-lane break-before-make data mux between functional and IJTAG sources.
// Each lane parks on PARK_VALUE for GUARD cycles whenever its source changes,
// so the two drivers of a lane are never observed back to back. A separate
// capture register snapshots the functional bus for shift-out.
//
// Lane FSM states:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   FUNC    | data_out follows functional_data_in
//   PARK_IJ | parked on PARK_VALUE, heading to the IJTAG source
//   IJTAG   | data_out follows ijtag_data_in, ijtag_active high
//   PARK_FN | parked on PARK_VALUE, heading to the functional source
module firebird7_in_gate1_tessent_data_mux_sw #(
  parameter int               WIDTH      = 19,
  parameter int               CHANNELS   = 3,
  parameter int               GUARD      = 2,
  parameter logic [WIDTH-1:0] PARK_VALUE = '0
) (
  input  logic                         ijtag_tck,
  input  logic                         ijtag_reset,
  input  logic [CHANNELS-1:0]          ijtag_select,
  input  logic [CHANNELS*WIDTH-1:0]    functional_data_in,
  input  logic [CHANNELS*WIDTH-1:0]    ijtag_data_in,
  input  logic                         capture_en,
  output logic [CHANNELS*WIDTH-1:0]    data_out,
  output logic [CHANNELS*WIDTH-1:0]    capture_data,
  output logic [CHANNELS-1:0]          ijtag_active,
  output logic [CHANNELS-1:0]          switch_busy
);

  typedef enum logic [1:0] {
    FUNC    = 2'd0,
    PARK_IJ = 2'd1,
    IJTAG   = 2'd2,
    PARK_FN = 2'd3
  } lane_state_t;

  // Guard counter counts down from GUARD-1 to 0 while parked; with GUARD=0
  // the park states are never entered and the reload value is irrelevant.
  localparam int         RELOAD_INT = (GUARD > 0) ? GUARD - 1 : 0;
  localparam logic [3:0] RELOAD     = RELOAD_INT[3:0];

  lane_state_t                 state_q [CHANNELS];
  lane_state_t                 state_d [CHANNELS];
  logic [3:0]                  cnt_q   [CHANNELS];
  logic [3:0]                  cnt_d   [CHANNELS];

  logic [CHANNELS*WIDTH-1:0]   data_d;
  logic [CHANNELS*WIDTH-1:0]   data_q;
  logic [CHANNELS-1:0]         busy_d;
  logic [CHANNELS-1:0]         busy_q;
  logic [CHANNELS-1:0]         active_d;
  logic [CHANNELS-1:0]         active_q;
  logic [CHANNELS*WIDTH-1:0]   capture_q;

  // Lane state and guard counter registers.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= FUNC;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  // Next-state logic; a request reversal while parked restarts the full guard
  // toward the newly requested source.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      case (state_q[k])
        FUNC: begin
          if (ijtag_select[k]) begin
            if (GUARD > 0) begin
              state_d[k] = PARK_IJ;
              cnt_d[k]   = RELOAD;
            end else begin
              state_d[k] = IJTAG;
            end
          end
        end
        PARK_IJ: begin
          if (!ijtag_select[k]) begin
            state_d[k] = PARK_FN;
            cnt_d[k]   = RELOAD;
          end else if (cnt_q[k] == 4'd0) begin
            state_d[k] = IJTAG;
          end else begin
            cnt_d[k] = cnt_q[k] - 4'd1;
          end
        end
        IJTAG: begin
          if (!ijtag_select[k]) begin
            if (GUARD > 0) begin
              state_d[k] = PARK_FN;
              cnt_d[k]   = RELOAD;
            end else begin
              state_d[k] = FUNC;
            end
          end
        end
        PARK_FN: begin
          if (ijtag_select[k]) begin
            state_d[k] = PARK_IJ;
            cnt_d[k]   = RELOAD;
          end else if (cnt_q[k] == 4'd0) begin
            state_d[k] = FUNC;
          end else begin
            cnt_d[k] = cnt_q[k] - 4'd1;
          end
        end
        default: begin
          state_d[k] = FUNC;
          cnt_d[k]   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so data_out tracks the source with
  // a single register of latency and parks on the same edge as the request.
  always_comb begin
    data_d   = '0;
    busy_d   = '0;
    active_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      data_d[k*WIDTH +: WIDTH] = PARK_VALUE;
      case (state_d[k])
        FUNC: begin
          data_d[k*WIDTH +: WIDTH] = functional_data_in[k*WIDTH +: WIDTH];
        end
        IJTAG: begin
          data_d[k*WIDTH +: WIDTH] = ijtag_data_in[k*WIDTH +: WIDTH];
          active_d[k]              = 1'b1;
        end
        PARK_IJ, PARK_FN: begin
          busy_d[k] = 1'b1;
        end
        default: begin
          busy_d[k] = 1'b0;
        end
      endcase
    end
  end

  // Registered lane outputs; reset parks every lane.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      data_q   <= {CHANNELS{PARK_VALUE}};
      busy_q   <= '0;
      active_q <= '0;
    end else begin
      data_q   <= data_d;
      busy_q   <= busy_d;
      active_q <= active_d;
    end
  end

  // Functional snapshot, independent of lane state; holds between requests.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      capture_q <= '0;
    end else if (capture_en) begin
      capture_q <= functional_data_in;
    end
  end

  assign data_out     = data_q;
  assign switch_busy  = busy_q;
  assign ijtag_active = active_q;
  assign capture_data = capture_q;

endmodule
